// File: rtl/rhs_frame_assembler.sv
// Collects one-channel-per-beat headstage samples into a full CHANNELS-wide frame.
// Only complete, in-order frames reach raw_data; everything else is dropped and counted.
module rhs_frame_assembler #(
  parameter int DATA_WIDTH     = 16,
  parameter int CHANNELS       = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture_enable,
  input  logic [DATA_WIDTH-1:0]          sample_data,
  input  logic [CW-1:0]                  sample_chan,
  input  logic                           sample_valid,
  input  logic                           err_clear,
  output logic [CHANNELS*DATA_WIDTH-1:0] raw_data,
  output logic                           data_valid,
  output logic                           busy,
  output logic [15:0]                    frame_count,
  output logic [15:0]                    drop_count,
  output logic                           seq_error,
  output logic                           dbg_state
);

  // Input handshake: sample_data/sample_chan are consumed on every cycle with
  // sample_valid=1; there is no backpressure, so a sample is either stored or dropped.

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t                                 state_q, state_d;
  logic [CW-1:0]                          expect_q, expect_d;
  logic [TW-1:0]                          timer_q, timer_d;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [CHANNELS*DATA_WIDTH-1:0]         raw_data_q, raw_data_d;
  logic                                   data_valid_q, data_valid_d;
  logic [15:0]                            frame_count_q, frame_count_d;
  logic [15:0]                            drop_count_q, drop_count_d;
  logic                                   seq_error_q, seq_error_d;

  logic store, complete, drop, seq_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      expect_q      <= '0;
      timer_q       <= '0;
      shadow_q      <= '0;
      raw_data_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      seq_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      expect_q      <= expect_d;
      timer_q       <= timer_d;
      shadow_q      <= shadow_d;
      raw_data_q    <= raw_data_d;
      data_valid_q  <= data_valid_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      seq_error_q   <= seq_error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    timer_d  = timer_q;
    store    = 1'b0;
    complete = 1'b0;
    drop     = 1'b0;
    seq_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_enable && sample_valid) begin
          if (sample_chan == '0) begin
            if (CHANNELS == 1) begin
              complete = 1'b1;
            end else begin
              store    = 1'b1;
              expect_d = CW'(1);
              timer_d  = '0;
              state_d  = COLLECT;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      COLLECT: begin
        // Disabling capture aborts the frame regardless of what else is on the input.
        if (!capture_enable) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (sample_valid) begin
          if (sample_chan == expect_q) begin
            timer_d = '0;
            if (expect_q == CW'(CHANNELS - 1)) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              store    = 1'b1;
              expect_d = expect_q + CW'(1);
            end
          end else if (sample_chan == '0) begin
            drop     = 1'b1;
            store    = 1'b1;
            expect_d = CW'(1);
            timer_d  = '0;
          end else begin
            drop    = 1'b1;
            seq_set = 1'b1;
            state_d = IDLE;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      expect_d = '0;
      timer_d  = '0;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (store && (sample_chan == CW'(k))) shadow_d[k] = sample_data;
    end
    // The final beat bypasses the shadow buffer so the frame is published in one step.
    raw_data_d = raw_data_q;
    if (complete) begin
      for (int k = 0; k < CHANNELS; k++) begin
        raw_data_d[k*DATA_WIDTH +: DATA_WIDTH] = (k == CHANNELS - 1) ? sample_data : shadow_q[k];
      end
    end
    data_valid_d  = complete;
    frame_count_d = (complete && (frame_count_q != 16'hFFFF)) ? frame_count_q + 16'd1 : frame_count_q;
    drop_count_d  = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;
    seq_error_d   = seq_set ? 1'b1 : (err_clear ? 1'b0 : seq_error_q);
  end

  always_comb begin
    busy        = (state_q == COLLECT);
    dbg_state   = state_q;
    raw_data    = raw_data_q;
    data_valid  = data_valid_q;
    frame_count = frame_count_q;
    drop_count  = drop_count_q;
    seq_error   = seq_error_q;
  end

endmodule

// File: tb/tb_rhs_frame_assembler.sv
// Directed bench for rhs_frame_assembler: completed frames are predicted into a
// queue when the last beat is driven and compared when data_valid pulses.
module tb_rhs_frame_assembler;

  localparam int DW = 16;
  localparam int CH = 8;
  localparam int FW = CH * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          capture_enable = 1'b1;
  logic [DW-1:0] sample_data = '0;
  logic [2:0]    sample_chan = '0;
  logic          sample_valid = 1'b0;
  logic          err_clear = 1'b0;
  logic [FW-1:0] raw_data;
  logic          data_valid, busy, seq_error, dbg_state;
  logic [15:0]   frame_count, drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_last = 0;
  int pulse_prev = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] last_frame = '0;

  rhs_frame_assembler #(.DATA_WIDTH(DW), .CHANNELS(CH), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .capture_enable(capture_enable),
    .sample_data(sample_data), .sample_chan(sample_chan), .sample_valid(sample_valid),
    .err_clear(err_clear), .raw_data(raw_data), .data_valid(data_valid), .busy(busy),
    .frame_count(frame_count), .drop_count(drop_count), .seq_error(seq_error),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every data_valid pulse must match the oldest predicted frame.
  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      pulse_prev = pulse_last;
      pulse_last = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_data_valid", 1, 0);
      end else begin
        chk("frame_data", raw_data, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [2:0] ch, input logic [DW-1:0] d);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    cycles(1);
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit rnd);
    logic [FW-1:0] f;
    logic [DW-1:0] d;
    f = '0;
    for (int k = 0; k < CH; k++) begin
      d = rnd ? DW'($urandom_range(0, 65535)) : base + DW'(k);
      f[k*DW +: DW] = d;
      if (k == CH - 1) begin
        exp_q.push_back(f);
        last_frame = f;
      end
      beat(3'(k), d);
    end
  endtask

  int p0;

  initial begin
    #2;
    chk("reset_raw", raw_data, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frames", frame_count, 0);
    chk("reset_drops", drop_count, 0);
    chk("reset_seq", seq_error, 0);
    cycles(2);
    reset = 1'b0;
    cycles(1);

    // 1: single frame, pulse one cycle after the last beat
    send_frame(16'h0100, 0);
    chk("t1_valid_pulse", data_valid, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_frames", frame_count, 1);
    cycles(1);
    chk("t1_valid_low", data_valid, 0);

    // 2: back-to-back frames
    p0 = pulses;
    send_frame(16'h1000, 0);
    send_frame(16'h2000, 0);
    cycles(1);
    chk("t2_pulses", pulses - p0, 2);
    chk("t2_spacing", pulse_last - pulse_prev, 8);
    chk("t2_frames", frame_count, 3);
    chk("t2_drops", drop_count, 0);

    // 3: out-of-order channel
    p0 = pulses;
    beat(0, 16'hAAAA); beat(1, 16'hBBBB); beat(2, 16'hCCCC); beat(5, 16'hDDDD);
    cycles(1);
    chk("t3_seq", seq_error, 1);
    chk("t3_drops", drop_count, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_pulse", pulses - p0, 0);
    chk("t3_raw_hold", raw_data, last_frame);
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
    chk("t3_seq_cleared", seq_error, 0);

    // 4: restart on channel 0, then stray channel in IDLE
    for (int k = 0; k < 4; k++) beat(3'(k), 16'h5500);
    chk("t4_busy_partial", busy, 1);
    send_frame(16'h0300, 0);
    cycles(1);
    chk("t4_drops", drop_count, 2);
    chk("t4_frames", frame_count, 4);
    beat(3, 16'h0033);
    chk("t4_idle_drop", drop_count, 3);
    chk("t4_idle_busy", busy, 0);

    // 5: timeout boundary
    for (int k = 0; k < 3; k++) beat(3'(k), 16'h7700);
    cycles(15);
    chk("t5_busy_before_timeout", busy, 1);
    chk("t5_drops_before_timeout", drop_count, 3);
    cycles(1);
    chk("t5_busy_after_timeout", busy, 0);
    chk("t5_drops_timeout", drop_count, 4);
    beat(3, 16'h7703);
    chk("t5_late_drop", drop_count, 5);

    // 6: capture_enable drop, disabled IDLE, seq_error then reset mid-frame
    for (int k = 0; k < 3; k++) beat(3'(k), 16'h8800);
    capture_enable = 1'b0;
    cycles(1);
    chk("t6_disable_drop", drop_count, 6);
    chk("t6_disable_busy", busy, 0);
    beat(3, 16'h8803);
    chk("t6_disabled_idle", drop_count, 6);
    capture_enable = 1'b1;
    send_frame(16'h0000, 1);
    cycles(1);
    chk("t6_frames", frame_count, 5);
    beat(0, 16'h1); beat(1, 16'h2); beat(3, 16'h3);
    chk("t6_seq", seq_error, 1);
    chk("t6_drops", drop_count, 7);
    for (int k = 0; k < 4; k++) beat(3'(k), 16'h9900);
    reset = 1'b1;
    #1;
    chk("t6_rst_raw", raw_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_frames", frame_count, 0);
    chk("t6_rst_drops", drop_count, 0);
    chk("t6_rst_seq", seq_error, 0);
    chk("t6_rst_valid", data_valid, 0);
    cycles(1);
    reset = 1'b0;
    cycles(1);

    // Drop counter saturation
    for (int i = 0; i < 65535; i++) beat(1, 16'h0);
    chk("sat_reach", drop_count, 16'hFFFF);
    beat(2, 16'h0);
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_frames", frame_count, 0);

    cycles(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
